// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the framed SPI configuration controller.
// Frame layout: an 8-bit command followed, for writes, by a 60-bit payload (MSB first).
package spi_ctrl_pkg;

  localparam int CFG_W      = 60;
  localparam int CMD_W      = 8;
  localparam int CNT_W      = 7;
  localparam int FRAME_BITS = CMD_W + CFG_W;

  localparam logic [CMD_W-1:0] CMD_WRITE = 8'hA5;
  localparam logic [CMD_W-1:0] CMD_TRIG  = 8'h5A;
  localparam logic [CFG_W-1:0] CFG_RST   = '0;

  // Field placement inside the active configuration word
  localparam int ENV_W   = 8;
  localparam int OSC_W   = 12;
  localparam int FILT_W  = 8;
  localparam int AI_LSB  = 0;
  localparam int DI_LSB  = 8;
  localparam int S_LSB   = 16;
  localparam int RI_LSB  = 24;
  localparam int OSC_LSB = 32;
  localparam int FA_LSB  = 44;
  localparam int FB_LSB  = 52;

  // Counter values seen on the edge that captures the last command / payload bit
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    WAIT_HI,
    IDLE,
    CMD,
    PAYLOAD,
    DONE_W,
    DONE_T,
    ERR
  } state_t;

endpackage

// File: rtl/spi_frame_rx.sv
// Bit-level receive path: frame bit counter, command shifter and payload shadow.
// The command word presented to the FSM already includes the bit being captured.
module spi_frame_rx
  import spi_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             mosi,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             cmd_en,
  input  logic             pay_en,
  output logic [CNT_W-1:0] cnt,
  output logic [CMD_W-1:0] cmd_word,
  output logic [CFG_W-1:0] shadow
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CMD_W-1:0] cmd_reg;
  logic [CFG_W-1:0] shadow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      cmd_reg    <= '0;
      shadow_reg <= '0;
    end else begin
      // Saturate rather than wrap so a long garbage frame never looks short
      if (clear)
        cnt_reg <= '0;
      else if (bit_en && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
      if (cmd_en)
        cmd_reg <= cmd_word;
      if (pay_en)
        shadow_reg <= {shadow_reg[CFG_W-2:0], mosi};
    end
  end

  assign cnt      = cnt_reg;
  assign cmd_word = {cmd_reg[CMD_W-2:0], mosi};
  assign shadow   = shadow_reg;

endmodule

// File: rtl/spi_ctrl.sv
// Framed SPI config controller: decodes write/trigger frames, shadows the voice
// config and commits it atomically at frame end; all outputs are registered.
module spi_ctrl
  import spi_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mosi,
  input  logic              nss,
  output logic [ENV_W-1:0]  adsr_ai,
  output logic [ENV_W-1:0]  adsr_di,
  output logic [ENV_W-1:0]  adsr_s,
  output logic [ENV_W-1:0]  adsr_ri,
  output logic [OSC_W-1:0]  osc_count,
  output logic [FILT_W-1:0] filter_a,
  output logic [FILT_W-1:0] filter_b,
  output logic              mute,
  output logic              trig,
  output logic              cfg_upd,
  output logic              frame_err
);

  state_t            state_reg, state_next;
  logic [CFG_W-1:0]  cfg_reg, cfg_next;
  logic              mute_reg, mute_next;
  logic              trig_reg, trig_next;
  logic              upd_reg, upd_next;
  logic              err_reg, err_next;

  logic              bit_en, cmd_en, pay_en;
  logic [CNT_W-1:0]  cnt;
  logic [CMD_W-1:0]  cmd_word;
  logic [CFG_W-1:0]  shadow;

  assign bit_en = !nss && (state_reg != WAIT_HI);
  assign cmd_en = !nss && ((state_reg == IDLE) || (state_reg == CMD));
  assign pay_en = !nss && (state_reg == PAYLOAD);

  spi_frame_rx u_rx (
    .clk      (clk),
    .rst      (rst),
    .mosi     (mosi),
    .clear    (nss),
    .bit_en   (bit_en),
    .cmd_en   (cmd_en),
    .pay_en   (pay_en),
    .cnt      (cnt),
    .cmd_word (cmd_word),
    .shadow   (shadow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WAIT_HI;
      cfg_reg   <= CFG_RST;
      mute_reg  <= 1'b0;
      trig_reg  <= 1'b0;
      upd_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cfg_reg   <= cfg_next;
      mute_reg  <= mute_next;
      trig_reg  <= trig_next;
      upd_reg   <= upd_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cfg_next   = cfg_reg;
    mute_next  = mute_reg;
    trig_next  = 1'b0;
    upd_next   = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      WAIT_HI: if (nss) state_next = IDLE;
      IDLE:    if (!nss) state_next = CMD;
      default: begin
        if (nss) begin
          // Frame end: act on whatever state the frame reached
          state_next = IDLE;
          mute_next  = 1'b0;
          case (state_reg)
            DONE_W: begin
              cfg_next = shadow;
              upd_next = 1'b1;
            end
            DONE_T:  trig_next = 1'b1;
            default: err_next  = 1'b1;
          endcase
        end else begin
          case (state_reg)
            CMD: if (cnt == CMD_LAST) begin
              if (cmd_word == CMD_WRITE) begin
                state_next = PAYLOAD;
                mute_next  = 1'b1;
              end else if (cmd_word == CMD_TRIG) begin
                state_next = DONE_T;
              end else begin
                state_next = ERR;
              end
            end
            PAYLOAD: if (cnt == PAY_LAST) state_next = DONE_W;
            DONE_W, DONE_T: state_next = ERR;
            default: state_next = state_reg;
          endcase
        end
      end
    endcase
  end

  assign adsr_ai   = cfg_reg[AI_LSB  +: ENV_W];
  assign adsr_di   = cfg_reg[DI_LSB  +: ENV_W];
  assign adsr_s    = cfg_reg[S_LSB   +: ENV_W];
  assign adsr_ri   = cfg_reg[RI_LSB  +: ENV_W];
  assign osc_count = cfg_reg[OSC_LSB +: OSC_W];
  assign filter_a  = cfg_reg[FA_LSB  +: FILT_W];
  assign filter_b  = cfg_reg[FB_LSB  +: FILT_W];
  assign mute      = mute_reg;
  assign trig      = trig_reg;
  assign cfg_upd   = upd_reg;
  assign frame_err = err_reg;

endmodule
